// File: rtl/fc_classifier.sv
// fc_classifier: fully-connected layer over a pooled CNN feature map.
// Collects N_POS beats, then runs one MAC per cycle across all classes.
module fc_classifier #(
    parameter  int CO      = 3,
    parameter  int IN_BW   = 20,
    parameter  int N_POS   = 16,
    parameter  int N_CLASS = 26,
    parameter  int W_BW    = 8,
    parameter  int ACC_BW  = 36,
    localparam int N_FEAT  = N_POS * CO,
    localparam int N_W     = N_CLASS * N_FEAT,
    localparam int AW      = $clog2(N_W),
    localparam int CW      = $clog2(N_CLASS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_ot_valid,
    input  logic [CO*IN_BW-1:0]      i_ot_result,
    input  logic                     i_w_we,
    input  logic [AW-1:0]            i_w_addr,
    input  logic signed [W_BW-1:0]   i_w_data,
    output logic                     o_busy,
    output logic                     o_valid,
    output logic [CW-1:0]            o_class,
    output logic signed [ACC_BW-1:0] o_score,
    output logic                     o_overrun
);

    localparam int PW = $clog2(N_POS);
    localparam int FW = $clog2(N_FEAT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;

    logic [1:0]               state;
    logic [PW-1:0]            pos;
    logic [FW-1:0]            fi;
    logic [CW-1:0]            cls;
    logic [AW-1:0]            raddr;
    logic signed [ACC_BW-1:0] acc;
    logic signed [ACC_BW-1:0] best;
    logic [CW-1:0]            best_cls;

    logic [IN_BW-1:0]         feat_buf [N_FEAT];
    logic signed [W_BW-1:0]   w_mem    [N_W];

    logic                     computing;
    logic                     accept;
    logic                     last_beat;
    logic                     last_feat;
    logic                     last_cls;
    logic                     take;
    logic signed [ACC_BW-1:0] fx;
    logic signed [ACC_BW-1:0] wx;
    logic signed [ACC_BW-1:0] prod;
    logic signed [ACC_BW-1:0] score;

    assign computing = (state == S_COMPUTE);
    assign accept    = i_ot_valid && !computing;
    assign last_beat = (pos == PW'(N_POS - 1));
    assign last_feat = (fi == FW'(N_FEAT - 1));
    assign last_cls  = (cls == CW'(N_CLASS - 1));
    assign o_busy    = computing;

    // Feature is unsigned: zero-extend before the signed multiply
    assign fx    = $signed({{(ACC_BW-IN_BW){1'b0}}, feat_buf[fi]});
    assign wx    = {{(ACC_BW-W_BW){w_mem[raddr][W_BW-1]}}, w_mem[raddr]};
    assign prod  = fx * wx;
    assign score = acc + prod;
    assign take  = (cls == '0) || (score > best);

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < CO; k++) begin
                feat_buf[FW'(int'(pos) * CO + k)] <=
                    i_ot_result[k*IN_BW +: IN_BW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_w_we && !computing && (int'(i_w_addr) < N_W)) begin
            w_mem[i_w_addr] <= i_w_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pos       <= '0;
            fi        <= '0;
            cls       <= '0;
            raddr     <= '0;
            acc       <= '0;
            best      <= '0;
            best_cls  <= '0;
            o_valid   <= 1'b0;
            o_class   <= '0;
            o_score   <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_ot_valid && computing) begin
                o_overrun <= 1'b1;
            end
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (i_ot_valid) begin
                        if (last_beat) begin
                            pos   <= '0;
                            state <= S_COMPUTE;
                        end else begin
                            pos   <= pos + 1'b1;
                            state <= S_COLLECT;
                        end
                    end
                end
                S_COMPUTE: begin
                    raddr <= raddr + 1'b1;
                    if (last_feat) begin
                        fi  <= '0;
                        acc <= '0;
                        if (take) begin
                            best     <= score;
                            best_cls <= cls;
                        end
                        if (last_cls) begin
                            cls     <= '0;
                            raddr   <= '0;
                            o_valid <= 1'b1;
                            o_class <= take ? cls : best_cls;
                            o_score <= take ? score : best;
                            state   <= S_IDLE;
                        end else begin
                            cls <= cls + 1'b1;
                        end
                    end else begin
                        fi  <= fi + 1'b1;
                        acc <= score;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_classifier.sv
// tb_fc_classifier: directed frames against a reference model,
// results matched through an expectation queue.
module tb_fc_classifier;

    localparam int CO      = 3;
    localparam int IN_BW   = 20;
    localparam int N_POS   = 16;
    localparam int N_CLASS = 26;
    localparam int W_BW    = 8;
    localparam int ACC_BW  = 36;
    localparam int N_FEAT  = N_POS * CO;
    localparam int N_W     = N_CLASS * N_FEAT;
    localparam int AW      = $clog2(N_W);
    localparam int CW      = $clog2(N_CLASS);

    logic                     clk;
    logic                     reset_n;
    logic                     i_ot_valid;
    logic [CO*IN_BW-1:0]      i_ot_result;
    logic                     i_w_we;
    logic [AW-1:0]            i_w_addr;
    logic signed [W_BW-1:0]   i_w_data;
    logic                     o_busy;
    logic                     o_valid;
    logic [CW-1:0]            o_class;
    logic signed [ACC_BW-1:0] o_score;
    logic                     o_overrun;

    fc_classifier dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_ot_valid  (i_ot_valid),
        .i_ot_result (i_ot_result),
        .i_w_we      (i_w_we),
        .i_w_addr    (i_w_addr),
        .i_w_data    (i_w_data),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_class     (o_class),
        .o_score     (o_score),
        .o_overrun   (o_overrun)
    );

    typedef struct {
        int     cls;
        longint score;
        longint at;
    } exp_t;

    exp_t                   q[$];
    exp_t                   mon_e;
    logic signed [W_BW-1:0] wm [N_W];
    int                     feats [N_FEAT];
    int                     n_chk = 0;
    int                     n_pass = 0;
    int                     last_cls = 0;
    longint                 last_score = 0;
    longint                 cyc = 0;
    longint                 target;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic predict(output int bc, output longint bs);
        bc = 0;
        bs = 0;
        for (int c = 0; c < N_CLASS; c++) begin
            longint s = 0;
            for (int f = 0; f < N_FEAT; f++) begin
                s += longint'(feats[f]) * longint'(wm[c*N_FEAT+f]);
            end
            if (c == 0 || s > bs) begin
                bc = c;
                bs = s;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && o_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", longint'(o_valid), 0);
            end else begin
                mon_e = q.pop_front();
                chk("class", longint'(o_class), longint'(mon_e.cls));
                chk("score", longint'(o_score), mon_e.score);
                chk("latency", cyc, mon_e.at);
                last_cls   = mon_e.cls;
                last_score = mon_e.score;
            end
        end
    end

    task automatic wr(input int a, input int d);
        i_w_we   = 1'b1;
        i_w_addr = AW'(a);
        i_w_data = W_BW'(d);
        wm[a]    = W_BW'(d);
        @(negedge clk);
        i_w_we   = 1'b0;
    endtask

    task automatic fill(input int v);
        for (int a = 0; a < N_W; a++) wr(a, v);
    endtask

    task automatic fill_rand();
        for (int a = 0; a < N_W; a++) begin
            wr(a, int'($urandom_range(255, 0)) - 128);
        end
    endtask

    task automatic feats_const(input int v);
        for (int f = 0; f < N_FEAT; f++) feats[f] = v;
    endtask

    task automatic feats_rand();
        for (int f = 0; f < N_FEAT; f++) begin
            feats[f] = int'($urandom_range((1 << IN_BW) - 1, 1));
        end
    endtask

    task automatic send_frame(input int gap_max);
        exp_t e;
        for (int p = 0; p < N_POS; p++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            if (p == N_POS - 1) begin
                predict(e.cls, e.score);
                e.at = cyc + 1 + N_W;
                q.push_back(e);
            end
            for (int k = 0; k < CO; k++) begin
                i_ot_result[k*IN_BW +: IN_BW] = IN_BW'(feats[p*CO+k]);
            end
            i_ot_valid = 1'b1;
            @(negedge clk);
            i_ot_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1500 && q.size() != 0; i++) @(negedge clk);
        chk("done_timeout", longint'(q.size()), 0);
        q.delete();
    endtask

    initial begin
        reset_n     = 1'b0;
        i_ot_valid  = 1'b0;
        i_ot_result = '0;
        i_w_we      = 1'b0;
        i_w_addr    = '0;
        i_w_data    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(o_busy), 0);
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_class", longint'(o_class), 0);
        chk("rst_score", longint'(o_score), 0);
        chk("rst_overrun", longint'(o_overrun), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // class 5 = +1, features 2 -> class 5, score 96
        fill(0);
        for (int f = 0; f < N_FEAT; f++) wr(5*N_FEAT + f, 1);
        feats_const(2);
        send_frame(0);
        chk("busy_compute", longint'(o_busy), 1);
        wait_done();
        chk("t1_class", longint'(last_cls), 5);
        chk("t1_score", last_score, 96);
        repeat (5) @(negedge clk);
        chk("hold_class", longint'(o_class), longint'(last_cls));
        chk("hold_score", longint'(o_score), last_score);

        // all zero weights: tie keeps class 0
        fill(0);
        feats_rand();
        send_frame(2);
        wait_done();

        // all -1 weights, then one zero weight in class 25
        fill(-1);
        feats_const(1);
        send_frame(0);
        wait_done();
        chk("t3a_score", last_score, -48);
        wr(25*N_FEAT + 7, 0);
        send_frame(0);
        wait_done();
        chk("t3b_class", longint'(last_cls), 25);
        chk("t3b_score", last_score, -47);

        // random weights, gapless vs gapped frame
        fill_rand();
        feats_rand();
        send_frame(0);
        wait_done();
        target = last_score;
        send_frame(3);
        wait_done();
        chk("gap_same", last_score, target);

        // beat and weight write during compute are both ignored
        chk("ovr_clear", longint'(o_overrun), 0);
        feats_rand();
        send_frame(0);
        repeat (20) @(negedge clk);
        i_ot_valid  = 1'b1;
        i_ot_result = {(CO*IN_BW){1'b1}};
        i_w_we      = 1'b1;
        i_w_addr    = AW'(25*N_FEAT);
        i_w_data    = ~wm[25*N_FEAT];
        @(negedge clk);
        i_ot_valid  = 1'b0;
        i_w_we      = 1'b0;
        chk("ovr_set", longint'(o_overrun), 1);
        wait_done();
        chk("ovr_sticky", longint'(o_overrun), 1);

        // reset mid-compute aborts; weights survive
        fill(0);
        for (int f = 0; f < N_FEAT; f++) wr(5*N_FEAT + f, 1);
        feats_const(2);
        send_frame(0);
        repeat (100) @(negedge clk);
        void'(q.pop_back());
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", longint'(o_busy), 0);
        chk("abort_overrun", longint'(o_overrun), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (1300) @(negedge clk);
        send_frame(0);
        wait_done();
        chk("t5_class", longint'(last_cls), 5);
        chk("t5_score", last_score, 96);

        // back-to-back: next frame starts in the o_valid cycle
        fill_rand();
        feats_rand();
        send_frame(0);
        target = q[0].at;
        for (int i = 0; i < 1400 && cyc != target; i++) @(negedge clk);
        chk("b2b_align", cyc, target);
        feats_rand();
        send_frame(0);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
